// File: rtl/i2s_in.sv
// I2S receiver: deserializes 16-bit left/right words from a synchronized serial stream
// and queues complete stereo frames in a small FIFO for the downstream filter.
module i2s_in #(
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2si_sck_transition,
    input  logic        i2si_ws,
    input  logic        i2si_sd,
    output logic        filt_rts,
    input  logic        filt_rtr,
    output logic [31:0] filt_data,
    input  logic        trig_fifo_overrun,
    output logic        ro_fifo_overrun
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    logic               r_ws_q;
    logic [15:0]        r_shift;
    logic [4:0]         r_bit_cnt;
    logic               r_sync;
    logic               r_left_valid;
    logic [15:0]        r_left;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overrun;
    logic [31:0]        r_mem [DEPTH];

    logic               w_boundary;
    logic [15:0]        w_shift_in;
    logic               w_cnt_full;
    logic [15:0]        w_word;
    logic               w_push_req;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_boundary = i2si_sck_transition && (i2si_ws != r_ws_q);
    assign w_shift_in = {r_shift[14:0], i2si_sd};
    assign w_cnt_full = r_bit_cnt[4];
    // Short words end up left-justified: shift the captured bits up by the missing slot count.
    assign w_word     = w_cnt_full ? r_shift : (w_shift_in << (4'd15 - r_bit_cnt[3:0]));
    assign w_push_req = w_boundary && r_ws_q && r_left_valid;

    assign w_full     = (r_count == DEPTH_C);
    assign filt_rts   = (r_count != '0);
    assign w_pop      = filt_rts && filt_rtr;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign filt_data       = filt_rts ? r_mem[r_rd_ptr] : 32'd0;
    assign ro_fifo_overrun = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ws_q       <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_sync       <= 1'b0;
            r_left_valid <= 1'b0;
            r_left       <= '0;
        end else if (i2si_sck_transition) begin
            r_ws_q <= i2si_ws;
            if (w_boundary) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_sync    <= 1'b1;
                if (!r_ws_q && r_sync) begin
                    r_left       <= w_word;
                    r_left_valid <= 1'b1;
                end else if (r_ws_q && r_left_valid) begin
                    r_left_valid <= 1'b0;
                end
            end else if (!w_cnt_full) begin
                r_shift   <= w_shift_in;
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            // A drop wins over a coincident clear so the loss is never hidden.
            if (w_drop)                 r_overrun <= 1'b1;
            else if (trig_fifo_overrun) r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_left, w_word};
    end

endmodule

// File: tb/tb_i2s_in.sv
// Directed testbench for i2s_in: frame capture, word-length handling, FIFO overrun and reset.
module tb_i2s_in;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i2si_sck_transition = 1'b0;
    logic        i2si_ws = 1'b0;
    logic        i2si_sd = 1'b0;
    logic        filt_rts;
    logic        filt_rtr = 1'b0;
    logic [31:0] filt_data;
    logic        trig_fifo_overrun = 1'b0;
    logic        ro_fifo_overrun;

    int checks = 0;
    int errors = 0;

    i2s_in #(.FIFO_AW(3)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i2si_sck_transition (i2si_sck_transition),
        .i2si_ws             (i2si_ws),
        .i2si_sd             (i2si_sd),
        .filt_rts            (filt_rts),
        .filt_rtr            (filt_rtr),
        .filt_data           (filt_data),
        .trig_fifo_overrun   (trig_fifo_overrun),
        .ro_fifo_overrun     (ro_fifo_overrun)
    );

    always #5 clk = ~clk;

    // One serial-clock tick lasting one clk cycle; p asserts filt_rtr on the same edge.
    task automatic tick(input logic w, input logic d, input logic p);
        i2si_sck_transition = 1'b1;
        i2si_ws  = w;
        i2si_sd  = d;
        filt_rtr = p;
        @(negedge clk);
        i2si_sck_transition = 1'b0;
        filt_rtr = 1'b0;
    endtask

    // I2S word: ws flips together with the LSB, one slot before the next channel's MSB.
    task automatic send_word(input logic ch, input logic [23:0] bits, input int n, input logic pop_last);
        for (int i = n - 1; i >= 0; i--) begin
            tick((i == 0) ? ~ch : ch, bits[i], (i == 0) ? pop_last : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n, input logic pop_last);
        send_word(1'b0, l, n, 1'b0);
        send_word(1'b1, r, n, pop_last);
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end else $display("ok   %s = %b", name, actual);
    endtask

    task automatic read_check(input string name, input logic [31:0] expected);
        checks++;
        if (filt_rts !== 1'b1 || filt_data !== expected) begin
            errors++;
            $display("FAIL %s: rts=%b data=%h, expected rts=1 data=%h", name, filt_rts, filt_data, expected);
        end else $display("ok   %s read %h", name, filt_data);
        filt_rtr = 1'b1;
        @(negedge clk);
        filt_rtr = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (filt_rts !== 1'b0 || filt_data !== 32'd0 || ro_fifo_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset: rts=%b data=%h ovr=%b, expected 0/0/0", filt_rts, filt_data, ro_fifo_overrun);
        end else $display("ok   reset outputs zero");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frames();
        send_frame(24'h00A5C3, 24'h001234, 16, 1'b0);
        check_bit("first_frame_dropped_rts", filt_rts, 1'b0);
        send_word(1'b0, 24'h00A5C3, 16, 1'b0);
        check_bit("rts_low_before_push", filt_rts, 1'b0);
        send_word(1'b1, 24'h001234, 16, 1'b0);
        check_bit("rts_high_after_push", filt_rts, 1'b1);
        send_frame(24'h00A5C3, 24'h001234, 16, 1'b0);
        read_check("basic_frame0", 32'hA5C31234);
        read_check("basic_frame1", 32'hA5C31234);
        check_bit("basic_empty", filt_rts, 1'b0);
    endtask

    task automatic test_long_words();
        send_frame(24'hFFFF5A, 24'h80013C, 24, 1'b0);
        read_check("long_24bit", 32'hFFFF8001);
        check_bit("long_empty", filt_rts, 1'b0);
    endtask

    task automatic test_short_words();
        send_frame(24'h000ABC, 24'h000123, 12, 1'b0);
        read_check("short_12bit", 32'hABC01230);
        check_bit("short_empty", filt_rts, 1'b0);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) send_frame(24'h001000 + i, 24'h002000 + i, 16, 1'b0);
        check_bit("ovr_after_8", ro_fifo_overrun, 1'b0);
        send_frame(24'h001008, 24'h002008, 16, 1'b0);
        check_bit("ovr_after_9", ro_fifo_overrun, 1'b1);
        trig_fifo_overrun = 1'b1;
        @(negedge clk);
        trig_fifo_overrun = 1'b0;
        check_bit("ovr_cleared", ro_fifo_overrun, 1'b0);
        trig_fifo_overrun = 1'b1;
        send_frame(24'h001009, 24'h002009, 16, 1'b0);
        trig_fifo_overrun = 1'b0;
        check_bit("ovr_set_beats_clear", ro_fifo_overrun, 1'b1);
        trig_fifo_overrun = 1'b1;
        @(negedge clk);
        trig_fifo_overrun = 1'b0;
        check_bit("ovr_cleared_again", ro_fifo_overrun, 1'b0);
    endtask

    task automatic test_full_push_pop();
        // Frame 0 pops on the same edge that frame 10 is pushed into the full FIFO.
        send_frame(24'h00100A, 24'h00200A, 16, 1'b1);
        check_bit("fullpp_no_overrun", ro_fifo_overrun, 1'b0);
        for (int i = 1; i < 8; i++) read_check($sformatf("fullpp_entry%0d", i), {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
        read_check("fullpp_last", 32'h100A200A);
        check_bit("fullpp_empty", filt_rts, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] r;
        r = 16'h1234;
        for (int i = 0; i < 3; i++) send_frame(24'h00A5C3, 24'h001234, 16, 1'b0);
        send_word(1'b0, 24'h00A5C3, 16, 1'b0);
        for (int i = 15; i >= 8; i--) tick(1'b1, r[i], 1'b0);
        check_bit("midrst_rts_before", filt_rts, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (filt_rts !== 1'b0 || filt_data !== 32'd0) begin
            errors++;
            $display("FAIL midrst_immediate: rts=%b data=%h, expected 0/0", filt_rts, filt_data);
        end else $display("ok   midrst_immediate outputs zero");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(1'b1, 24'h000034, 8, 1'b0);
        check_bit("midrst_after_tail", filt_rts, 1'b0);
        send_word(1'b0, 24'h00BEEF, 16, 1'b0);
        check_bit("midrst_after_left", filt_rts, 1'b0);
        send_word(1'b1, 24'h00CAFE, 16, 1'b0);
        read_check("midrst_new_frame", 32'hBEEFCAFE);
        check_bit("midrst_empty", filt_rts, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frames();
        test_long_words();
        test_short_words();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_in.md
I2S_IN -- requirements
Module: i2s_in

Interface
REQ-001 SHALL provide parameter FIFO_AW, default 3, meaning frame FIFO depth is 2**FIFO_AW entries (8).
REQ-002 SHALL provide port clk  input  1  master clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port i2si_sck_transition  input  1  one-clk pulse per serial-clock rising edge, from the upstream synchronizer.
REQ-005 SHALL provide port i2si_ws  input  1  word select, already synchronized to clk; 0 = left, 1 = right.
REQ-006 SHALL provide port i2si_sd  input  1  serial data, already synchronized to clk, MSB first.
REQ-007 SHALL provide port filt_rts  output  1  FIFO not empty; a frame is ready to send to the filter.
REQ-008 SHALL provide port filt_rtr  input  1  filter is ready to read.
REQ-009 SHALL provide port filt_data  output  32  head frame: [31:16] left, [15:0] right.
REQ-010 SHALL provide port trig_fifo_overrun  input  1  clears ro_fifo_overrun.
REQ-011 SHALL provide port ro_fifo_overrun  output  1  sticky flag: a frame was dropped because the FIFO was full.

Function
REQ-012 SHALL sample i2si_ws and i2si_sd only in clk cycles where i2si_sck_transition=1 (a "tick"); all other cycles hold the deserializer state.
REQ-013 SHALL register ws_q (the ws value sampled at the previous tick); the sd bit sampled at a tick belongs to channel ws_q (one-bit I2S delay).
REQ-014 SHALL, on each tick, shift sd into the channel shift register while the bit counter is below 16, and increment the counter, saturating at 16; bits beyond 16 are discarded.
REQ-015 SHALL detect a word boundary at a tick where the sampled ws differs from ws_q; the bit taken at that tick is the LSB slot of channel ws_q.
REQ-016 SHALL, at a boundary, left-justify the captured word: fewer than 16 bits are zero-padded at the LSBs.
REQ-017 SHALL, at a boundary, clear the shift register and counter so that the next tick captures the MSB of the new channel.
REQ-018 SHALL hold a sync flag that is cleared by reset and set at the first boundary; words that complete while sync=0 are discarded.
REQ-019 SHALL, at a left-word boundary (ws_q=0) with sync=1, latch the word into the left holding register and set left_valid.
REQ-020 SHALL, at a right-word boundary (ws_q=1) with left_valid=1, push {left, right} into the FIFO on that same clk edge and clear left_valid.
REQ-021 SHALL discard a right word that arrives with left_valid=0, with no push and no flag change.
REQ-022 SHALL implement the FIFO with 2**FIFO_AW x 32 storage and read/write pointers that wrap modulo the depth.
REQ-023 SHALL drive filt_rts = (count != 0) and filt_data = the head entry, with the head visible in the same cycle that filt_rts is high.
REQ-024 SHALL pop one entry on each clk edge where filt_rts & filt_rtr are both 1.
REQ-025 SHALL raise filt_rts in the cycle after a push into an empty FIFO (one clk of latency).
REQ-026 SHALL accept a push when count < depth, or when count = depth and a pop occurs on the same edge.
REQ-027 SHALL, when a push occurs with count = depth and no pop, drop the frame, leave the FIFO unchanged, and set ro_fifo_overrun to 1.
REQ-028 SHALL give ro_fifo_overrun set priority over clear when trig_fifo_overrun coincides with a drop; otherwise trig_fifo_overrun=1 clears it to 0.
REQ-029 SHALL, on a simultaneous push and pop, leave count unchanged and update both pointers.

Reset
REQ-030 SHALL, while rst_n=0, immediately force filt_rts=0, filt_data=0, and ro_fifo_overrun=0.
REQ-031 SHALL, while rst_n=0, immediately force count, pointers, shift register, bit counter, ws_q, sync, and left_valid to 0.
REQ-032 SHALL discard all FIFO contents and any partial frame when reset is asserted mid-operation.
REQ-033 SHALL, after reset release, require a new boundary before any capture (REQ-018).

Verification
REQ-034 SHALL cover this case: send 3 full 16-bit stereo frames with L=0xA5C3 and R=0x1234 -> the first partial frame is dropped, then frames read as 0xA5C31234 in order, with filt_rts high 1 clk after the push.
REQ-035 SHALL cover this case: send 24 sck per channel, L MSBs=0xFFFF and R MSBs=0x8001 -> filt_data=0xFFFF8001, with the extra 8 bits ignored.
REQ-036 SHALL cover this case: send 12 sck per channel, L bits=0xABC and R bits=0x123 -> filt_data=0xABC01230.
REQ-037 SHALL cover this case: hold filt_rtr=0 and push 9 frames -> 8 are stored, the 9th is dropped, ro_fifo_overrun=1; a trig pulse then clears it to 0, and trig coinciding with a drop leaves it at 1.
REQ-038 SHALL cover this case: FIFO full with filt_rtr=1 on the same edge as a push -> the frame is accepted, count stays 8, and ro_fifo_overrun stays 0.
REQ-039 SHALL cover this case: assert rst_n=0 mid-right-word with 3 frames queued -> filt_rts=0 immediately; after release, no output until a new boundary plus a full L and R pair.
